// File: rtl/alu_cmd_unit.sv
// ---------------------------------------------------------------------------
// alu_cmd_unit
// Command-driven ALU with a valid/ready handshake on both sides. Add/sub and
// the bitwise ops finish in one cycle. Logical shifts run one bit per cycle
// through a working register.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  command handshake (ready only while IDLE)
//   opcode, a, b         000 ADD, 001 XOR, 010 AND, 011 OR, 100 NOR,
//                        101 SLL, 110 SRL, 111 reserved (result 0)
//   cin, sub             carry-in for ADD; sub=1 selects a - b
//   rsp_valid/rsp_ready  response handshake (valid only in DONE)
//   result, cout         result and carry / no-borrow / last shifted-out bit
//   busy                 high whenever the unit is not IDLE
//   status               {overflow, negative, zero}; present only when
//                        ALU_CMD_STATUS_EN is defined
// ---------------------------------------------------------------------------
module alu_cmd_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
`ifdef ALU_CMD_STATUS_EN
    ,
    output logic [2:0]       status
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             cout_reg, cout_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic             dir_reg, dir_next;     // 1 = shift right

    // Subtraction is a + ~b + 1, so cin only matters when sub=0.
    logic [WIDTH-1:0] b_op;
    logic             c_op;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;

    assign b_op  = sub ? ~b : b;
    assign c_op  = sub ? 1'b1 : cin;
    assign sum   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_op};
    assign shamt = b[SHW-1:0];

`ifdef ALU_CMD_STATUS_EN
    logic [2:0] status_reg, status_next;
    logic       add_ovf;

    // Signed overflow: operands agree in sign but the sum does not.
    assign add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign status  = status_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            cnt_reg    <= '0;
            dir_reg    <= 1'b0;
`ifdef ALU_CMD_STATUS_EN
            status_reg <= 3'b000;
`endif
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            cout_reg   <= cout_next;
            cnt_reg    <= cnt_next;
            dir_reg    <= dir_next;
`ifdef ALU_CMD_STATUS_EN
            status_reg <= status_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        cout_next   = cout_reg;
        cnt_next    = cnt_reg;
        dir_next    = dir_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = DONE;
                    cout_next  = 1'b0;
                    cnt_next   = '0;
                    case (opcode)
                        OP_ADD: {cout_next, result_next} = sum;
                        OP_XOR: result_next = a ^ b;
                        OP_AND: result_next = a & b;
                        OP_OR:  result_next = a | b;
                        OP_NOR: result_next = ~(a | b);
                        OP_SLL, OP_SRL: begin
                            // Load the operand; a zero amount finishes as-is.
                            result_next = a;
                            dir_next    = (opcode == OP_SRL);
                            if (shamt != '0) begin
                                cnt_next   = shamt;
                                state_next = SHIFT;
                            end
                        end
                        default: result_next = '0;
                    endcase
                end
            end
            SHIFT: begin
                if (dir_reg) begin
                    result_next = result_reg >> 1;
                    cout_next   = result_reg[0];
                end else begin
                    result_next = result_reg << 1;
                    cout_next   = result_reg[WIDTH-1];
                end
                cnt_next = cnt_reg - SHW'(1);
                if (cnt_reg == SHW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ALU_CMD_STATUS_EN
    // Flags follow whatever value is written into the result register.
    always_comb begin
        status_next = status_reg;
        if ((state_reg == IDLE && req_valid) || state_reg == SHIFT) begin
            status_next = {(state_reg == IDLE && opcode == OP_ADD) ? add_ovf : 1'b0,
                           result_next[WIDTH-1],
                           (result_next == '0)};
        end
    end
`endif

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
    assign cout      = cout_reg;

endmodule
